fpu_comp_pipe: RTL and testbench
================================

Name: fpu_comp_pipe

Overview:
- Parametrised, 2-stage pipelined floating-point compare / min / max unit for any IEEE-style format (sign | EXP_W | FRAC_W).
- Adds features a flat FP16 comparator lacks:
  - op-selectable results (EQ/LT/LE/MIN/MAX);
  - correct ±0 equality;
  - an unordered flag and an invalid flag for NaNs;
  - valid/ready handshaking with full backpressure.
- Sits on the FPU result path beside the adder and multiplier.

Parameters:
- EXP_W, 5, exponent field width (≥2).
- FRAC_W, 10, fraction field width (≥2).
- W, 1+EXP_W+FRAC_W, derived operand width; not to be overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- op  in  3  000 EQ, 001 LT, 010 LE, 011 MIN, 100 MAX; 101–111 illegal.
- a, b  in  W  operands.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- res  out  W  result: boolean in bit 0 with upper bits zero for compare ops; operand value for MIN/MAX.
- lt, eq, gt  out  1  ordered relation of a vs b; always produced, for every op.
- unord  out  1  at least one operand is NaN.
- invalid  out  1  IEEE invalid-operation exception for this beat.
- sticky_invalid  out  1  accumulated invalid (optional feature).
- clr_sticky  in  1  synchronous clear of sticky_invalid.

Behaviour:
- Reset (async assert, sync release): all stage valids 0; out_valid=0, res=0, lt=eq=gt=unord=invalid=0, sticky_invalid=0.
- Classification: NaN = exponent all ones and frac≠0; sNaN = NaN with frac MSB 0; Inf = exponent all ones and frac=0; Zero = exponent 0 and frac 0. Subnormals are ordered by magnitude; no flush.
- Stage 1 registers a, b, op and the class bits of both operands. Stage 2 registers res and all flags.
- Latency: 2 cycles from an accepted beat to out_valid when no stall occurs. Throughput: 1 beat per cycle.
- Handshake:
  - A beat transfers on valid&ready at either side.
  - s2 advances when ~s2_valid | out_ready. s1 advances when ~s1_valid | s2 advances.
  - in_ready is that s1 condition; it depends combinationally on out_ready.
  - Outputs hold stable while out_valid & ~out_ready.
  - in_valid may drop without a handshake.
- Ordering:
  - Magnitude comparison uses {exp,frac}. Signs are handled as in sign-magnitude.
  - +0 and −0 compare equal: eq=1, lt=gt=0.
  - ±Inf order naturally and Inf==Inf of the same sign.
  - Any NaN: lt=eq=gt=0, unord=1. Otherwise exactly one of lt/eq/gt is 1 and unord=0.
- invalid:
  - EQ: any sNaN.
  - LT/LE (signalling): any NaN.
  - MIN/MAX: any sNaN.
  - Illegal op: always 1, with res=0 and lt/eq/gt/unord still computed.
- MIN/MAX:
  - min(−0,+0)=−0 and max(−0,+0)=+0, in either operand order.
  - Exactly one NaN (quiet or signalling): the result is the other operand.
  - Both NaN: canonical qNaN = sign 0, exponent all ones, frac MSB 1, rest 0.
- A reset mid-operation discards all in-flight beats.

Optional Feature:
- FPU_COMP_STICKY_EN defined: sticky_invalid sets on every delivered beat (out_valid&out_ready) whose invalid=1.
  - clr_sticky clears it next cycle.
  - Same-cycle set and clear: set wins.
- Not defined: sticky_invalid is tied 0 and clr_sticky is ignored; the port list is unchanged.

Decomposition:
- fpu_pkg holds: fp_op_e enum (EQ/LT/LE/MIN/MAX), fp_class_t struct (isNaN, isSNaN, isInf, isZero, sign), and the function that returns the canonical qNaN for a given EXP_W/FRAC_W.
- One sub-module, fpu_classify, parametrised by EXP_W/FRAC_W, is instantiated twice in stage 1.

Test Plan:
- FP16, op=LT, a=0x3C00 (1.0), b=0xC000 (−2.0) → 2 cycles later: res=0, gt=1, lt=eq=0, unord=0, invalid=0.
- op=EQ, a=0x8000, b=0x0000 → res=1, eq=1. op=MIN with the same operands → res=0x8000. op=MAX, b/a swapped → res=0x0000.
- op=MIN, a=0x7D00 (sNaN), b=0xFC00 (−Inf) → res=0xFC00, unord=1, invalid=1. op=MAX, a=0x7E00, b=0x7D00 → res=0x7E00 (canonical qNaN), invalid=1.
- op=LE, a=0x7E00 (qNaN), b=0x3C00 → res=0, unord=1, invalid=1. op=EQ, same operands → invalid=0.
- Stream 6 back-to-back beats while holding out_ready=0 for cycles 3–6:
  - in_ready drops after 2 beats are buffered.
  - Results stay stable while stalled.
  - All 6 results emerge in order with none lost or duplicated.
- Assert reset_n low while 2 beats are in flight → out_valid=0 immediately and asynchronously. After release, a new beat completes in 2 cycles. With FPU_COMP_STICKY_EN: one invalid beat sets sticky_invalid, and clr_sticky clears it next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared types and helpers for the FPU compare/min/max path.
//   fp_op_e    : operation select encoding (3 bits, 101-111 are illegal)
//   fp_class_t : per-operand classification bits
//   canonQNaN  : canonical quiet NaN for a given exponent/fraction width,
//                returned right-aligned in a 64-bit vector
// -----------------------------------------------------------------------------
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_LT  = 3'b001,
        OP_LE  = 3'b010,
        OP_MIN = 3'b011,
        OP_MAX = 3'b100
    } fp_op_e;

    typedef struct packed {
        logic isNaN;
        logic isSNaN;
        logic isInf;
        logic isZero;
        logic sign;
    } fp_class_t;

    // Sign 0, exponent all ones, fraction MSB 1, rest 0: that is a run of
    // EXP_W+1 ones starting at bit FRAC_W-1.
    function automatic logic [63:0] canonQNaN(input int expW, input int fracW);
        logic [63:0] ones;
        ones = (64'd1 << (expW + 1)) - 64'd1;
        return ones << (fracW - 1);
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// -----------------------------------------------------------------------------
// fpu_classify
// Combinational classifier for one IEEE-style operand (sign | EXP_W | FRAC_W).
//   operand : input operand
//   cls     : NaN / signalling NaN / infinity / zero flags plus sign
// Subnormals are not flagged; they are ordered as ordinary magnitudes.
// -----------------------------------------------------------------------------
module fpu_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic [EXP_W+FRAC_W:0] operand,
    output fp_class_t             cls
);

    logic [EXP_W-1:0]  expo;
    logic [FRAC_W-1:0] frac;
    logic              expOnes;
    logic              expZero;
    logic              fracZero;

    assign expo     = operand[FRAC_W +: EXP_W];
    assign frac     = operand[FRAC_W-1:0];
    assign expOnes  = &expo;
    assign expZero  = ~|expo;
    assign fracZero = ~|frac;

    assign cls.isNaN  = expOnes & ~fracZero;
    // Quiet/signalling is told apart by the fraction MSB.
    assign cls.isSNaN = expOnes & ~fracZero & ~frac[FRAC_W-1];
    assign cls.isInf  = expOnes & fracZero;
    assign cls.isZero = expZero & fracZero;
    assign cls.sign   = operand[EXP_W+FRAC_W];

endmodule

// File: rtl/fpu_comp_pipe.sv
// -----------------------------------------------------------------------------
// fpu_comp_pipe
// Two-stage pipelined floating-point compare / min / max unit with
// valid/ready handshaking and full backpressure.
//
// Ports:
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : operand beat handshake (in_ready is combinational
//                           on out_ready)
//   op                    : 000 EQ, 001 LT, 010 LE, 011 MIN, 100 MAX, else illegal
//   a, b                  : operands (sign | EXP_W | FRAC_W)
//   out_valid / out_ready : result beat handshake
//   res                   : boolean in bit 0 for compares, operand for MIN/MAX
//   lt, eq, gt, unord     : ordered relation of a vs b, unordered if any NaN
//   invalid               : IEEE invalid-operation flag for this beat
//   sticky_invalid        : accumulated invalid over delivered beats
//   clr_sticky            : synchronous clear of sticky_invalid
//
// Build option: define FPU_COMP_STICKY_EN to enable sticky_invalid; without it
// sticky_invalid is tied 0 and clr_sticky is ignored.
// -----------------------------------------------------------------------------
module fpu_comp_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic         lt,
    output logic         eq,
    output logic         gt,
    output logic         unord,
    output logic         invalid,
    output logic         sticky_invalid,
    input  logic         clr_sticky
);

    localparam logic [63:0]  QNAN_WIDE = canonQNaN(EXP_W, FRAC_W);
    localparam logic [W-1:0] QNAN      = QNAN_WIDE[W-1:0];

    logic adv1;
    logic adv2;

    fp_class_t clsA;
    fp_class_t clsB;

    logic         vld_p1;
    logic [W-1:0] a_p1;
    logic [W-1:0] b_p1;
    logic [2:0]   op_p1;
    fp_class_t    clsA_p1;
    fp_class_t    clsB_p1;

    logic         vld_p2;
    logic [W-1:0] res_p2;
    logic         lt_p2;
    logic         eq_p2;
    logic         gt_p2;
    logic         unord_p2;
    logic         invalid_p2;

    logic [W-2:0] magA;
    logic [W-2:0] magB;
    logic         anyNaN;
    logic         anySNaN;
    logic         ltN;
    logic         eqN;
    logic         gtN;
    logic         pickMinA;
    logic         pickMaxA;
    logic [W-1:0] minRes;
    logic [W-1:0] maxRes;
    logic [W-1:0] resN;
    logic         invN;

    // Stage 2 drains when empty or the consumer takes the beat; stage 1 when
    // empty or stage 2 moves on.
    assign adv2     = ~vld_p2 | out_ready;
    assign adv1     = ~vld_p1 | adv2;
    assign in_ready = adv1;

    fpu_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_classA (
        .operand (a),
        .cls     (clsA)
    );

    fpu_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_classB (
        .operand (b),
        .cls     (clsB)
    );

    // ---- Stage 1: operands, op and class bits ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (adv1 && in_valid) begin
            a_p1    <= a;
            b_p1    <= b;
            op_p1   <= op;
            clsA_p1 <= clsA;
            clsB_p1 <= clsB;
        end
    end

    // ---- Stage 1 -> 2 combinational evaluation ----
    assign magA    = a_p1[W-2:0];
    assign magB    = b_p1[W-2:0];
    assign anyNaN  = clsA_p1.isNaN | clsB_p1.isNaN;
    assign anySNaN = clsA_p1.isSNaN | clsB_p1.isSNaN;

    always_comb begin
        ltN = 1'b0;
        eqN = 1'b0;
        gtN = 1'b0;
        if (anyNaN) begin
            // unordered: all relations stay 0
        end else if ((clsA_p1.isZero & clsB_p1.isZero) |
                     (clsA_p1.isInf & clsB_p1.isInf & (clsA_p1.sign == clsB_p1.sign))) begin
            eqN = 1'b1;
        end else if (clsA_p1.sign != clsB_p1.sign) begin
            ltN = clsA_p1.sign;
            gtN = ~clsA_p1.sign;
        end else if (magA == magB) begin
            eqN = 1'b1;
        end else if (clsA_p1.sign) begin
            // Both negative: larger magnitude is the smaller value.
            ltN = magA > magB;
            gtN = magA < magB;
        end else begin
            ltN = magA < magB;
            gtN = magA > magB;
        end
    end

    // With two zeros the sign decides, so min(-0,+0) = -0 in either order.
    assign pickMinA = (clsA_p1.isZero & clsB_p1.isZero) ? clsA_p1.sign  : (ltN | eqN);
    assign pickMaxA = (clsA_p1.isZero & clsB_p1.isZero) ? ~clsA_p1.sign : (gtN | eqN);

    always_comb begin
        minRes = pickMinA ? a_p1 : b_p1;
        maxRes = pickMaxA ? a_p1 : b_p1;
        // A single NaN is dropped in favour of the number.
        if (clsA_p1.isNaN & clsB_p1.isNaN) begin
            minRes = QNAN;
            maxRes = QNAN;
        end else if (clsA_p1.isNaN) begin
            minRes = b_p1;
            maxRes = b_p1;
        end else if (clsB_p1.isNaN) begin
            minRes = a_p1;
            maxRes = a_p1;
        end
    end

    always_comb begin
        resN = '0;
        invN = 1'b0;
        case (op_p1)
            OP_EQ: begin
                resN = {{(W-1){1'b0}}, eqN};
                invN = anySNaN;
            end
            OP_LT: begin
                resN = {{(W-1){1'b0}}, ltN};
                invN = anyNaN;
            end
            OP_LE: begin
                resN = {{(W-1){1'b0}}, ltN | eqN};
                invN = anyNaN;
            end
            OP_MIN: begin
                resN = minRes;
                invN = anySNaN;
            end
            OP_MAX: begin
                resN = maxRes;
                invN = anySNaN;
            end
            default: begin
                resN = '0;
                invN = 1'b1;
            end
        endcase
    end

    // ---- Stage 2: result and flags ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2     <= 1'b0;
            res_p2     <= '0;
            lt_p2      <= 1'b0;
            eq_p2      <= 1'b0;
            gt_p2      <= 1'b0;
            unord_p2   <= 1'b0;
            invalid_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2     <= resN;
                lt_p2      <= ltN;
                eq_p2      <= eqN;
                gt_p2      <= gtN;
                unord_p2   <= anyNaN;
                invalid_p2 <= invN;
            end
        end
    end

    assign out_valid = vld_p2;
    assign res       = res_p2;
    assign lt        = lt_p2;
    assign eq        = eq_p2;
    assign gt        = gt_p2;
    assign unord     = unord_p2;
    assign invalid   = invalid_p2;

`ifdef FPU_COMP_STICKY_EN
    logic sticky_q;

    // Set has priority over clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else if (vld_p2 && out_ready && invalid_p2) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_invalid = sticky_q;
`else
    logic unusedClrSticky;

    assign unusedClrSticky = clr_sticky;
    assign sticky_invalid  = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_comp_pipe.sv
// -----------------------------------------------------------------------------
// tb_fpu_comp_pipe
// Directed FP16 vectors with hand-computed expectations for fpu_comp_pipe:
// compare ops, signed zeros, NaN/Inf handling, illegal op, a stalled stream,
// asynchronous reset and the optional sticky invalid flag.
// -----------------------------------------------------------------------------
module tb_fpu_comp_pipe;
    import fpu_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic        lt;
    logic        eq;
    logic        gt;
    logic        unord;
    logic        invalid;
    logic        sticky_invalid;
    logic        clr_sticky;

    int nVec = 0;
    int nErr = 0;

    fpu_comp_pipe #(.EXP_W(5), .FRAC_W(10)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .a              (a),
        .b              (b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .res            (res),
        .lt             (lt),
        .eq             (eq),
        .gt             (gt),
        .unord          (unord),
        .invalid        (invalid),
        .sticky_invalid (sticky_invalid),
        .clr_sticky     (clr_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {lt, eq, gt, unord, invalid};
    endfunction

    // One beat with out_ready held high; checks the 2-cycle latency and result.
    // Ends on the negedge where the result is visible; the next edge delivers it.
    task automatic runBeat(input string tag, input logic [2:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] expRes,
                           input logic [4:0] expFlags);
        @(negedge clock);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        chkVal({tag, "_early"}, out_valid, 0);
        @(negedge clock);
        chkVal({tag, "_valid"}, out_valid, 1);
        chkVal({tag, "_res"}, res, expRes);
        chkVal({tag, "_flags"}, flags(), expFlags);
    endtask

    logic [15:0] streamA   [6] = '{16'h4000, 16'h4200, 16'h3800, 16'h4400, 16'h7C00, 16'h4500};
    logic [15:0] streamExp [6] = '{16'h4000, 16'h4200, 16'h3C00, 16'h4400, 16'h7C00, 16'h4500};

    initial begin
        int          sent;
        int          recvd;
        logic        stalledPrev;
        logic [15:0] held;

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        op         = 3'b000;
        a          = '0;
        b          = '0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;

        repeat (2) @(negedge clock);
        chkVal("rst_valid", out_valid, 0);
        chkVal("rst_res", res, 0);
        chkVal("rst_flags", flags(), 0);
        chkVal("rst_sticky", sticky_invalid, 0);
        reset_n = 1'b1;

        // flags order: {lt, eq, gt, unord, invalid}
        runBeat("lt_pos_neg",  OP_LT,  16'h3C00, 16'hC000, 16'h0000, 5'b00100);
        runBeat("eq_zeros",    OP_EQ,  16'h8000, 16'h0000, 16'h0001, 5'b01000);
        runBeat("min_zeros",   OP_MIN, 16'h8000, 16'h0000, 16'h8000, 5'b01000);
        runBeat("max_zeros",   OP_MAX, 16'h0000, 16'h8000, 16'h0000, 5'b01000);
        runBeat("min_zeros_r", OP_MIN, 16'h0000, 16'h8000, 16'h8000, 5'b01000);
        runBeat("min_snan",    OP_MIN, 16'h7D00, 16'hFC00, 16'hFC00, 5'b00011);
        runBeat("max_2nan",    OP_MAX, 16'h7E00, 16'h7D00, 16'h7E00, 5'b00011);
        runBeat("le_qnan",     OP_LE,  16'h7E00, 16'h3C00, 16'h0000, 5'b00011);
        runBeat("eq_qnan",     OP_EQ,  16'h7E00, 16'h3C00, 16'h0000, 5'b00010);
        runBeat("lt_pos",      OP_LT,  16'h3C00, 16'h4000, 16'h0001, 5'b10000);
        runBeat("lt_subn",     OP_LT,  16'h0001, 16'h0002, 16'h0001, 5'b10000);
        runBeat("lt_neg",      OP_LT,  16'hC000, 16'hBC00, 16'h0001, 5'b10000);
        runBeat("le_equal",    OP_LE,  16'hBC00, 16'hBC00, 16'h0001, 5'b01000);
        runBeat("max_inf",     OP_MAX, 16'h3C00, 16'h7C00, 16'h7C00, 5'b10000);
        runBeat("eq_inf",      OP_EQ,  16'h7C00, 16'h7C00, 16'h0001, 5'b01000);
        runBeat("illegal_op",  3'b101, 16'h3C00, 16'h3C00, 16'h0000, 5'b01001);

        // Sticky invalid after an invalid beat (the previous beat was also
        // invalid, so its delivery already counts).
        runBeat("min_snan2",   OP_MIN, 16'h7D00, 16'hFC00, 16'hFC00, 5'b00011);
        @(negedge clock);
`ifdef FPU_COMP_STICKY_EN
        chkVal("sticky_set", sticky_invalid, 1);
        clr_sticky = 1'b1;
        @(negedge clock);
        clr_sticky = 1'b0;
        chkVal("sticky_clr", sticky_invalid, 0);
`else
        chkVal("sticky_off", sticky_invalid, 0);
`endif

        // Stream of 6 MAX(a_i, 1.0) beats with the consumer stalled in cycles 3-6.
        sent        = 0;
        recvd       = 0;
        stalledPrev = 1'b0;
        held        = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 6);
            op        = OP_MAX;
            a         = (sent < 6) ? streamA[sent] : 16'h0000;
            b         = 16'h3C00;
            #1;
            if (stalledPrev) chkVal("stall_hold", res, held);
            if (c >= 3 && c <= 6) chkVal("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (recvd < 6) chkVal($sformatf("stream_res%0d", recvd), res, streamExp[recvd]);
                recvd++;
            end
            stalledPrev = out_valid && !out_ready;
            held        = res;
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chkVal("stream_sent", sent, 6);
        chkVal("stream_recvd", recvd, 6);

        // Reset with two beats in flight.
        @(negedge clock);
        in_valid = 1'b1;
        op       = OP_LT;
        a        = 16'h3C00;
        b        = 16'h4000;
        @(posedge clock);
        @(negedge clock);
        a = 16'h4000;
        b = 16'h3C00;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chkVal("rst_async_valid", out_valid, 0);
        chkVal("rst_async_res", res, 0);
        chkVal("rst_async_flags", flags(), 0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        runBeat("after_rst", OP_LT, 16'h3C00, 16'h4000, 16'h0001, 5'b10000);
        @(negedge clock);
        chkVal("after_rst_drain", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
